// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared opcodes, strobe indices, state encoding and counter width
package alu_seq_pkg;
    localparam int CNT_W   = 4;
    localparam int NUM_OPS = 13;

    localparam logic [3:0] OP_AND   = 4'd0;
    localparam logic [3:0] OP_OR    = 4'd1;
    localparam logic [3:0] OP_ADD   = 4'd2;
    localparam logic [3:0] OP_SUB   = 4'd3;
    localparam logic [3:0] OP_MUL   = 4'd4;
    localparam logic [3:0] OP_DIV   = 4'd5;
    localparam logic [3:0] OP_SHR   = 4'd6;
    localparam logic [3:0] OP_SHL   = 4'd7;
    localparam logic [3:0] OP_ROR   = 4'd8;
    localparam logic [3:0] OP_ROL   = 4'd9;
    localparam logic [3:0] OP_NEG   = 4'd10;
    localparam logic [3:0] OP_NOT   = 4'd11;
    localparam logic [3:0] OP_INCPC = 4'd12;

    localparam int CTRL_AND   = 0;
    localparam int CTRL_OR    = 1;
    localparam int CTRL_ADD   = 2;
    localparam int CTRL_SUB   = 3;
    localparam int CTRL_MUL   = 4;
    localparam int CTRL_DIV   = 5;
    localparam int CTRL_SHR   = 6;
    localparam int CTRL_SHL   = 7;
    localparam int CTRL_ROR   = 8;
    localparam int CTRL_ROL   = 9;
    localparam int CTRL_NEG   = 10;
    localparam int CTRL_NOT   = 11;
    localparam int CTRL_INCPC = 12;

    typedef enum logic {IDLE, EXEC} state_t;
endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: opcode to one-hot ALU strobe, mul/div class and illegal flag
module alu_op_decode
    import alu_seq_pkg::*;
(
    input  logic [3:0]         opcode,
    output logic [NUM_OPS-1:0] onehot,
    output logic               is_muldiv,
    output logic               illegal
);
    // codes above IncPC have no strobe, so they decode to all-zero
    always_comb begin
        illegal   = opcode > OP_INCPC;
        onehot    = illegal ? '0 : NUM_OPS'(1) << opcode;
        is_muldiv = onehot[CTRL_MUL] | onehot[CTRL_DIV];
    end
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issues one ALU op per handshake, waits its latency, captures result
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int ALU_LAT    = 1,
    parameter int MULDIV_LAT = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               ready,
    input  logic [3:0]         opcode,
    input  logic [31:0]        a_in,
    input  logic [31:0]        b_in,
    output logic [NUM_OPS-1:0] alu_ctrl,
    output logic [31:0]        alu_a,
    output logic [31:0]        alu_b,
    input  logic [63:0]        alu_c,
    output logic [31:0]        z_hi,
    output logic [31:0]        z_lo,
    output logic               done,
    output logic               err
);
    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt;
    logic [NUM_OPS-1:0] onehot;
    logic               is_muldiv, illegal;

    alu_op_decode u_dec (
        .opcode    (opcode),
        .onehot    (onehot),
        .is_muldiv (is_muldiv),
        .illegal   (illegal)
    );

    assign ready = state == IDLE;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    // accept on start in IDLE, return to IDLE once the latency count has drained
    always_comb begin
        state_d = state;
        if (state == IDLE && start)    state_d = EXEC;
        else if (state == EXEC && cnt == '0) state_d = IDLE;
    end

    // operand/strobe issue, latency countdown and result capture; an all-zero strobe marks an illegal op
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            alu_ctrl <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            z_hi     <= '0;
            z_lo     <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    alu_a    <= a_in;
                    alu_b    <= b_in;
                    alu_ctrl <= onehot;
                    cnt      <= illegal ? '0 : is_muldiv ? CNT_W'(MULDIV_LAT) : CNT_W'(ALU_LAT);
                end
            end else if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end else begin
                if (alu_ctrl != '0) begin
                    z_hi <= alu_c[63:32];
                    z_lo <= alu_c[31:0];
                end
                alu_ctrl <= '0;
                done     <= 1'b1;
                err      <= alu_ctrl == '0;
            end
        end
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed checks of the sequencer against a registered ALU model
module tb_alu_op_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        ready;
    logic [3:0]  opcode = '0;
    logic [31:0] a_in = '0;
    logic [31:0] b_in = '0;
    logic [12:0] alu_ctrl;
    logic [31:0] alu_a, alu_b, z_hi, z_lo;
    logic [63:0] alu_c = '0;
    logic        done, err;
    logic [3:0]  d_op = '0;
    logic [12:0] d_oh;
    logic        d_md, d_ill;
    int          total = 0;
    int          passed = 0;
    int          n;

    always #5 clk = ~clk;

    alu_op_sequencer #(.ALU_LAT(1), .MULDIV_LAT(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ready(ready), .opcode(opcode),
        .a_in(a_in), .b_in(b_in), .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
        .alu_c(alu_c), .z_hi(z_hi), .z_lo(z_lo), .done(done), .err(err)
    );

    alu_op_decode u_dec (.opcode(d_op), .onehot(d_oh), .is_muldiv(d_md), .illegal(d_ill));

    // one-cycle registered ALU model
    always @(posedge clk) begin
        if (alu_ctrl[0])       alu_c <= {32'd0, alu_a & alu_b};
        else if (alu_ctrl[1])  alu_c <= {32'd0, alu_a | alu_b};
        else if (alu_ctrl[2])  alu_c <= {32'd0, alu_a + alu_b};
        else if (alu_ctrl[3])  alu_c <= {32'd0, alu_a - alu_b};
        else if (alu_ctrl[4])  alu_c <= {32'd0, alu_a} * {32'd0, alu_b};
        else if (alu_ctrl[5])  alu_c <= (alu_b == 0) ? 64'd0 : {alu_a % alu_b, alu_a / alu_b};
        else if (alu_ctrl[6])  alu_c <= {32'd0, alu_a >> alu_b[4:0]};
        else if (alu_ctrl[7])  alu_c <= {32'd0, alu_a << alu_b[4:0]};
        else if (alu_ctrl[8])  alu_c <= {32'd0, (alu_a >> alu_b[4:0]) | (alu_a << (6'd32 - {1'b0, alu_b[4:0]}))};
        else if (alu_ctrl[9])  alu_c <= {32'd0, (alu_a << alu_b[4:0]) | (alu_a >> (6'd32 - {1'b0, alu_b[4:0]}))};
        else if (alu_ctrl[10]) alu_c <= {32'd0, -alu_a};
        else if (alu_ctrl[11]) alu_c <= {32'd0, ~alu_a};
        else if (alu_ctrl[12]) alu_c <= {32'd0, alu_a + 32'd1};
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else passed++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 20) begin
            step();
            cyc++;
        end
    endtask

    // strobe must stay one-hot-or-zero; err never without done
    always @(negedge clk) begin
        if (rst_n && $countones(alu_ctrl) > 1) chk("ctrl_onehot", 64'(alu_ctrl), 64'(0));
        if (err && !done) chk("err_without_done", 64'(err), 64'(0));
    end

    initial begin
        for (int c = 0; c < 16; c++) begin
            d_op = 4'(c);
            #1;
            chk($sformatf("dec_oh_%0d", c), 64'(d_oh), (c < 13) ? 64'(13'd1 << c) : 64'd0);
            chk($sformatf("dec_md_%0d", c), 64'(d_md), 64'(c == 4 || c == 5));
            chk($sformatf("dec_ill_%0d", c), 64'(d_ill), 64'(c > 12));
        end

        start = 1'b1; opcode = 4'd2; a_in = 32'd7; b_in = 32'd7;
        repeat (3) step();
        chk("rst_ctrl", 64'(alu_ctrl), 64'd0);
        chk("rst_a", 64'(alu_a), 64'd0);
        chk("rst_b", 64'(alu_b), 64'd0);
        chk("rst_z", {z_hi, z_lo}, 64'd0);
        chk("rst_done_err", 64'({done, err}), 64'd0);
        start = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("rst_ready", 64'(ready), 64'd1);

        step();
        start = 1'b1; opcode = 4'd2; a_in = 32'd4; b_in = 32'd1;
        step();
        start = 1'b0;
        chk("add_ctrl1", 64'(alu_ctrl), 64'h004);
        chk("add_ready", 64'(ready), 64'd0);
        chk("add_ops", {alu_a, alu_b}, {32'd4, 32'd1});
        step();
        chk("add_ctrl2", 64'(alu_ctrl), 64'h004);
        chk("add_early", 64'(done), 64'd0);
        step();
        chk("add_done", 64'({done, err, ready}), 64'b101);
        chk("add_z", {z_hi, z_lo}, 64'd5);
        chk("add_ctrl_clr", 64'(alu_ctrl), 64'd0);
        step();
        chk("add_done_pulse", 64'(done), 64'd0);

        start = 1'b1; opcode = 4'd4; a_in = 32'h0001_0000; b_in = 32'h0001_0000;
        step();
        start = 1'b0;
        chk("mul_ctrl1", 64'(alu_ctrl), 64'h010);
        step();
        step();
        chk("mul_ctrl3", 64'(alu_ctrl), 64'h010);
        chk("mul_early", 64'(done), 64'd0);
        step();
        chk("mul_done", 64'({done, err}), 64'b10);
        chk("mul_z", {z_hi, z_lo}, 64'h0000_0001_0000_0000);
        step();

        start = 1'b1; opcode = 4'd6; a_in = 32'd4; b_in = 32'd1;
        step();
        opcode = 4'd9; a_in = 32'h8000_0000; b_in = 32'd1;
        chk("shr_ctrl", 64'(alu_ctrl), 64'h040);
        step();
        chk("shr_no_resample", {alu_a, 19'd0, alu_ctrl}, {32'd4, 19'd0, 13'h040});
        step();
        chk("shr_done", 64'({done, err, ready}), 64'b101);
        chk("shr_z", {z_hi, z_lo}, 64'd2);
        step();
        start = 1'b0;
        chk("rol_accept", {alu_a, 19'd0, alu_ctrl}, {32'h8000_0000, 19'd0, 13'h200});
        chk("rol_done_clr", 64'(done), 64'd0);
        wait_done(n);
        chk("rol_lat", 64'(n), 64'd2);
        chk("rol_z", {z_hi, z_lo}, 64'd1);
        step();

        start = 1'b1; opcode = 4'd14; a_in = 32'hdead; b_in = 32'hbeef;
        step();
        start = 1'b0;
        chk("ill_ctrl", 64'(alu_ctrl), 64'd0);
        chk("ill_ready", 64'(ready), 64'd0);
        step();
        chk("ill_done", 64'({done, err, ready}), 64'b111);
        chk("ill_z_kept", {z_hi, z_lo}, 64'd1);
        step();
        chk("ill_pulse", 64'({done, err}), 64'd0);

        start = 1'b1; opcode = 4'd5; a_in = 32'd100; b_in = 32'd7;
        step();
        start = 1'b0;
        chk("div_ctrl", 64'(alu_ctrl), 64'h020);
        step();
        rst_n = 1'b0;
        #1;
        chk("arst_ctrl", 64'(alu_ctrl), 64'd0);
        chk("arst_ops", {alu_a, alu_b}, 64'd0);
        chk("arst_z", {z_hi, z_lo}, 64'd0);
        chk("arst_ready", 64'(ready), 64'd1);
        step();
        rst_n = 1'b1;
        wait_done(n);
        chk("arst_no_done", 64'(n), 64'd20);
        start = 1'b1; opcode = 4'd2; a_in = 32'd10; b_in = 32'd20;
        step();
        start = 1'b0;
        wait_done(n);
        chk("post_add_lat", 64'(n), 64'd2);
        chk("post_add_z", {z_hi, z_lo}, 64'd30);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
